// File: rtl/rps_round_ctrl.sv
// rtl/rps_round_ctrl.sv - rock-paper-scissors round controller: key debounce, judging, scoring
// Publishes each judged round as a one-cycle comb_valid pulse for the move predictors.
module rps_round_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ROUNDS          = 60,
  parameter int unsigned MAX_SCORE       = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       throw_key,
  input  logic [1:0] user_move,
  input  logic [1:0] ai_choice,
  output logic [3:0] combination,
  output logic       comb_valid,
  output logic [1:0] result,
  output logic [7:0] reward,
  output logic [6:0] user_score,
  output logic [6:0] ai_score,
  output logic [5:0] round_count,
  output logic       err_move,
  output logic       game_over
);

  localparam logic [1:0] MV_ROCK     = 2'b00;
  localparam logic [1:0] MV_SCISSORS = 2'b01;
  localparam logic [1:0] MV_PAPER    = 2'b10;
  localparam logic [1:0] MV_ILLEGAL  = 2'b11;

  localparam logic [1:0] RES_DRAW = 2'b00;
  localparam logic [1:0] RES_USER = 2'b01;
  localparam logic [1:0] RES_AI   = 2'b10;

  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]  ROUNDS_L  = 6'(ROUNDS);
  localparam logic [6:0]  MAX_SCORE_L = 7'(MAX_SCORE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCK,
    S_JUDGE,
    S_REPORT,
    S_RELEASE,
    S_DONE
  } state_t;

  logic        r_key_meta;
  logic        r_key_sync_n;
  logic        w_key_sync;
  logic [15:0] r_db_cnt;
  logic        r_db_state;
  logic        r_db_prev;
  logic        w_press;

  state_t      r_state;
  logic [1:0]  r_user_mv;
  logic [1:0]  r_ai_mv;
  logic [3:0]  r_combination;
  logic        r_comb_valid;
  logic [1:0]  r_result;
  logic [7:0]  r_reward;
  logic [6:0]  r_user_score;
  logic [6:0]  r_ai_score;
  logic [5:0]  r_round_count;
  logic        r_err_move;
  logic        r_game_over;

  logic [1:0]  w_result;
  logic [7:0]  w_reward;
  logic [6:0]  w_user_score_nxt;
  logic [6:0]  w_ai_score_nxt;
  logic [5:0]  w_round_nxt;

  // Synchroniser flops idle at the released (high) key level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_key_meta   <= 1'b1;
      r_key_sync_n <= 1'b1;
    end else begin
      r_key_meta   <= throw_key;
      r_key_sync_n <= r_key_meta;
    end
  end

  assign w_key_sync = ~r_key_sync_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_db_cnt   <= 16'd0;
      r_db_state <= 1'b0;
      r_db_prev  <= 1'b0;
    end else begin
      r_db_prev <= r_db_state;
      if (w_key_sync == r_db_state) begin
        r_db_cnt <= 16'd0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_state <= ~r_db_state;
        r_db_cnt   <= 16'd0;
      end else begin
        r_db_cnt <= r_db_cnt + 16'd1;
      end
    end
  end

  assign w_press = r_db_state & ~r_db_prev;

  always_comb begin
    w_result = RES_DRAW;
    case ({r_user_mv, r_ai_mv})
      {MV_ROCK, MV_SCISSORS},
      {MV_SCISSORS, MV_PAPER},
      {MV_PAPER, MV_ROCK}:     w_result = RES_USER;
      {MV_SCISSORS, MV_ROCK},
      {MV_PAPER, MV_SCISSORS},
      {MV_ROCK, MV_PAPER}:     w_result = RES_AI;
      default:                 w_result = RES_DRAW;
    endcase
  end

  always_comb begin
    w_reward = 8'h00;
    case (w_result)
      RES_USER: w_reward = 8'hFF;
      RES_AI:   w_reward = 8'h01;
      default:  w_reward = 8'h00;
    endcase
  end

  assign w_user_score_nxt = ((w_result == RES_USER) && (r_user_score < MAX_SCORE_L))
                            ? r_user_score + 7'd1 : r_user_score;
  assign w_ai_score_nxt   = ((w_result == RES_AI) && (r_ai_score < MAX_SCORE_L))
                            ? r_ai_score + 7'd1 : r_ai_score;
  assign w_round_nxt      = r_round_count + 6'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_user_mv     <= MV_ROCK;
      r_ai_mv       <= MV_ROCK;
      r_combination <= 4'd0;
      r_comb_valid  <= 1'b0;
      r_result      <= RES_DRAW;
      r_reward      <= 8'h00;
      r_user_score  <= 7'd0;
      r_ai_score    <= 7'd0;
      r_round_count <= 6'd0;
      r_err_move    <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_press) begin
            r_state <= S_LOCK;
          end
        end
        S_LOCK: begin
          r_user_mv <= user_move;
          r_ai_mv   <= ai_choice;
          if (user_move == MV_ILLEGAL) begin
            r_err_move <= 1'b1;
            r_state    <= S_RELEASE;
          end else begin
            r_state <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          r_combination <= {r_ai_mv, r_user_mv};
          r_result      <= w_result;
          r_reward      <= w_reward;
          r_user_score  <= w_user_score_nxt;
          r_ai_score    <= w_ai_score_nxt;
          r_round_count <= w_round_nxt;
          r_err_move    <= 1'b0;
          r_game_over   <= (w_round_nxt == ROUNDS_L);
          r_comb_valid  <= 1'b1;
          r_state       <= S_REPORT;
        end
        S_REPORT: begin
          r_comb_valid <= 1'b0;
          r_state      <= r_game_over ? S_DONE : S_RELEASE;
        end
        // Waiting for the debounced release stops a long hold from scoring twice.
        S_RELEASE: begin
          if (!r_db_state) begin
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign combination = r_combination;
  assign comb_valid  = r_comb_valid;
  assign result      = r_result;
  assign reward      = r_reward;
  assign user_score  = r_user_score;
  assign ai_score    = r_ai_score;
  assign round_count = r_round_count;
  assign err_move    = r_err_move;
  assign game_over   = r_game_over;

endmodule
